pipe_fwd_ctrl: RTL and testbench

Parametrised forwarding and hazard controller for the next-generation five-stage core. It keeps a shadow pipeline of destination tags for every in-flight instruction between ID and write-back. Each cycle it selects, per register read port, either the register-file value or the youngest in-flight result. It stalls IF/ID when a needed result (a load) is not yet available, and counts stall cycles.

---
 rtl/pipe_fwd_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_fwd_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_fwd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_fwd_ctrl: operand forwarding and load-use hazard control            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module pipe_fwd_ctrl #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int NREAD      = 2,
  parameter int NSTAGE     = 3,
  parameter int LATE_STAGE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid_i,
  input  logic                 id_wreg_i,
  input  logic [AW-1:0]        id_wd_i,
  input  logic                 id_late_i,
  input  logic [NREAD*AW-1:0]  raddr_i,
  input  logic [NREAD-1:0]     re_i,
  input  logic [NREAD*DW-1:0]  rdata_i,
  input  logic [NSTAGE*DW-1:0] stage_data_i,
  input  logic                 hold_i,
  input  logic                 flush_i,
  output logic [NREAD*DW-1:0]  operand_o,
  output logic                 stall_o,
  output logic [31:0]          stall_cnt_o
);

  logic [NSTAGE-1:0]         r_valid;
  logic [NSTAGE-1:0]         r_wreg;
  logic [NSTAGE-1:0]         r_late;
  logic [NSTAGE-1:0][AW-1:0] r_wd;
  logic [31:0]               r_stall_cnt;
  logic [NREAD-1:0]          w_hazard;
  logic                      w_stall;

  for (genvar r = 0; r < NREAD; r++) begin : g_port
    logic [AW-1:0] w_raddr;
    logic          w_hit;
    logic          w_rdy;
    logic [DW-1:0] w_fwd;

    assign w_raddr = raddr_i[r*AW +: AW];

    // Scan oldest to youngest so the lowest-index match is the last one kept.
    always_comb begin
      w_hit = 1'b0;
      w_rdy = 1'b0;
      w_fwd = '0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (r_valid[k] && r_wreg[k] && (r_wd[k] == w_raddr) &&
            (w_raddr != '0) && re_i[r]) begin
          w_hit = 1'b1;
          w_rdy = !r_late[k] || (k >= LATE_STAGE);
          w_fwd = stage_data_i[k*DW +: DW];
        end
      end
    end

    assign w_hazard[r]            = w_hit && !w_rdy;
    assign operand_o[r*DW +: DW]  = (w_hit && w_rdy) ? w_fwd : rdata_i[r*DW +: DW];
  end

  assign w_stall     = rst && (|w_hazard);
  assign stall_o     = w_stall;
  assign stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid     <= '0;
      r_wreg      <= '0;
      r_late      <= '0;
      r_wd        <= '0;
      r_stall_cnt <= '0;
    end else if (!hold_i) begin
      if (flush_i || w_stall) begin
        r_valid[0] <= 1'b0;
        r_wreg[0]  <= 1'b0;
        r_late[0]  <= 1'b0;
        r_wd[0]    <= '0;
      end else begin
        r_valid[0] <= id_valid_i;
        r_wreg[0]  <= id_wreg_i;
        r_late[0]  <= id_late_i;
        r_wd[0]    <= id_wd_i;
      end
      // A flush also kills the instruction that was in EX.
      for (int k = 1; k < NSTAGE; k++) begin
        if ((k == 1) && flush_i) begin
          r_valid[k] <= 1'b0;
          r_wreg[k]  <= 1'b0;
          r_late[k]  <= 1'b0;
          r_wd[k]    <= '0;
        end else begin
          r_valid[k] <= r_valid[k-1];
          r_wreg[k]  <= r_wreg[k-1];
          r_late[k]  <= r_late[k-1];
          r_wd[k]    <= r_wd[k-1];
        end
      end
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_fwd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_fwd_ctrl: directed scoreboard bench for pipe_fwd_ctrl            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_pipe_fwd_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREAD = 2;
  localparam int NSTAGE = 3;

  localparam int c_OP0 = 0;
  localparam int c_OP1 = 1;
  localparam int c_STALL = 2;
  localparam int c_CNT = 3;

  logic                 clk;
  logic                 rst;
  logic                 id_valid_i;
  logic                 id_wreg_i;
  logic [AW-1:0]        id_wd_i;
  logic                 id_late_i;
  logic [NREAD*AW-1:0]  raddr_i;
  logic [NREAD-1:0]     re_i;
  logic [NREAD*DW-1:0]  rdata_i;
  logic [NSTAGE*DW-1:0] stage_data_i;
  logic                 hold_i;
  logic                 flush_i;
  logic [NREAD*DW-1:0]  operand_o;
  logic                 stall_o;
  logic [31:0]          stall_cnt_o;

  typedef struct {
    int          kind;
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int checks = 0;
  int failures = 0;

  pipe_fwd_ctrl #(.DW(DW), .AW(AW), .NREAD(NREAD), .NSTAGE(NSTAGE), .LATE_STAGE(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid_i   (id_valid_i),
    .id_wreg_i    (id_wreg_i),
    .id_wd_i      (id_wd_i),
    .id_late_i    (id_late_i),
    .raddr_i      (raddr_i),
    .re_i         (re_i),
    .rdata_i      (rdata_i),
    .stage_data_i (stage_data_i),
    .hold_i       (hold_i),
    .flush_i      (flush_i),
    .operand_o    (operand_o),
    .stall_o      (stall_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int kind, input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.kind = kind;
    it.tag  = tag;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  task automatic pop_check();
    sb_item_t    it;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.kind)
        c_OP0:   obs = operand_o[31:0];
        c_OP1:   obs = operand_o[63:32];
        c_STALL: obs = {31'd0, stall_o};
        default: obs = stall_cnt_o;
      endcase
      checks++;
      assert (obs === it.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic check_at_negedge();
    @(negedge clk);
    pop_check();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic w, input logic [AW-1:0] wd, input logic late);
    id_valid_i = v;
    id_wreg_i  = w;
    id_wd_i    = wd;
    id_late_i  = late;
  endtask

  task automatic drive_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] re);
    raddr_i = {a1, a0};
    re_i    = re;
  endtask

  task automatic idle(input int n);
    drive_id(1'b0, 1'b0, '0, 1'b0);
    re_i    = '0;
    flush_i = 1'b0;
    hold_i  = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b0;
    drive_id(1'b0, 1'b0, '0, 1'b0);
    drive_rd(5'd1, 5'd1, 2'b11);
    rdata_i      = {32'hAAAA_0001, 32'h5555_0000};
    stage_data_i = '0;
    hold_i       = 1'b0;
    flush_i      = 1'b0;
    tick();
    tick();

    // Reset state
    push(c_STALL, "reset_stall", 32'd0);
    push(c_CNT,   "reset_cnt",   32'd0);
    push(c_OP0,   "reset_op0",   32'h5555_0000);
    push(c_OP1,   "reset_op1",   32'hAAAA_0001);
    check_at_negedge();
    rst = 1'b1;
    idle(1);

    // ALU chain: add $1 then add $2,$1,$1
    drive_id(1'b1, 1'b1, 5'd1, 1'b0);
    tick();
    drive_id(1'b1, 1'b1, 5'd2, 1'b0);
    drive_rd(5'd1, 5'd1, 2'b11);
    rdata_i      = '0;
    stage_data_i = {32'd0, 32'd0, 32'h0000_0005};
    push(c_OP0,   "alu_op0",   32'h0000_0005);
    push(c_OP1,   "alu_op1",   32'h0000_0005);
    push(c_STALL, "alu_stall", 32'd0);
    check_at_negedge();
    tick();
    idle(3);

    // Load-use: lw $3 then add $4,$3,$0
    drive_id(1'b1, 1'b1, 5'd3, 1'b1);
    tick();
    drive_id(1'b1, 1'b1, 5'd4, 1'b0);
    drive_rd(5'd3, 5'd0, 2'b11);
    rdata_i      = {32'h0000_0077, 32'h0000_0066};
    stage_data_i = {32'd0, 32'hDEAD_BEEF, 32'h1234_5678};
    push(c_STALL, "lu_stall",    32'd1);
    push(c_OP0,   "lu_op0_rf",   32'h0000_0066);
    push(c_OP1,   "lu_op1_zero", 32'h0000_0077);
    push(c_CNT,   "lu_cnt0",     32'd0);
    check_at_negedge();
    tick();
    push(c_STALL, "lu_stall_off", 32'd0);
    push(c_OP0,   "lu_op0_mem",   32'hDEAD_BEEF);
    push(c_OP1,   "lu_op1_zero2", 32'h0000_0077);
    push(c_CNT,   "lu_cnt1",      32'd1);
    check_at_negedge();
    tick();
    idle(3);

    // Two writes to $5 in flight; youngest wins, then older stages
    drive_id(1'b1, 1'b1, 5'd5, 1'b0);
    tick();
    tick();
    drive_id(1'b0, 1'b0, '0, 1'b0);
    drive_rd(5'd5, 5'd0, 2'b01);
    rdata_i      = {32'd0, 32'h0000_00AB};
    stage_data_i = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    push(c_OP0,   "yw_ex",    32'h0000_0011);
    push(c_STALL, "yw_stall", 32'd0);
    check_at_negedge();
    tick();
    push(c_OP0, "yw_mem", 32'h0000_0022);
    check_at_negedge();
    tick();
    push(c_OP0, "yw_wb", 32'h0000_0033);
    check_at_negedge();
    idle(3);

    // Write to $0 never forwards
    drive_id(1'b1, 1'b1, 5'd0, 1'b0);
    tick();
    drive_id(1'b0, 1'b0, '0, 1'b0);
    drive_rd(5'd0, 5'd0, 2'b01);
    rdata_i      = '0;
    stage_data_i = {32'd0, 32'd0, 32'h0000_0099};
    push(c_OP0,   "r0_op0",   32'd0);
    push(c_STALL, "r0_stall", 32'd0);
    check_at_negedge();
    idle(3);

    // Flush over a pending load hazard
    drive_id(1'b1, 1'b1, 5'd6, 1'b1);
    tick();
    drive_id(1'b1, 1'b1, 5'd7, 1'b0);
    drive_rd(5'd6, 5'd0, 2'b01);
    rdata_i      = {32'd0, 32'h0000_0010};
    stage_data_i = {32'h0000_0E03, 32'h0000_0E02, 32'h0000_0E01};
    flush_i      = 1'b1;
    push(c_STALL, "fl_stall_before", 32'd1);
    check_at_negedge();
    tick();
    flush_i = 1'b0;
    drive_id(1'b0, 1'b0, '0, 1'b0);
    push(c_STALL, "fl_stall_after", 32'd0);
    push(c_OP0,   "fl_op0",         32'h0000_0010);
    push(c_CNT,   "fl_cnt",         32'd2);
    check_at_negedge();
    idle(3);

    // Hold during a load-use stall
    drive_id(1'b1, 1'b1, 5'd8, 1'b1);
    tick();
    drive_id(1'b1, 1'b1, 5'd9, 1'b0);
    drive_rd(5'd8, 5'd0, 2'b01);
    rdata_i      = {32'd0, 32'h0000_0020};
    stage_data_i = {32'd0, 32'hCAFE_0000, 32'h0000_0BAD};
    hold_i       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(c_STALL, $sformatf("hold_stall_%0d", i), 32'd1);
      push(c_CNT,   $sformatf("hold_cnt_%0d", i),   32'd2);
      push(c_OP0,   $sformatf("hold_op0_%0d", i),   32'h0000_0020);
      check_at_negedge();
      tick();
    end
    hold_i = 1'b0;
    push(c_STALL, "hold_rel_stall", 32'd1);
    check_at_negedge();
    tick();
    push(c_STALL, "hold_done_stall", 32'd0);
    push(c_OP0,   "hold_done_op0",   32'hCAFE_0000);
    push(c_CNT,   "hold_done_cnt",   32'd3);
    check_at_negedge();
    idle(3);

    // Reset pulse during an active stall
    drive_id(1'b1, 1'b1, 5'd9, 1'b1);
    tick();
    drive_id(1'b1, 1'b1, 5'd10, 1'b0);
    drive_rd(5'd9, 5'd0, 2'b01);
    rdata_i      = {32'h0000_0031, 32'h0000_0030};
    stage_data_i = {32'd0, 32'hFEED_0000, 32'h0000_0ABC};
    push(c_STALL, "rs_stall_pre", 32'd1);
    push(c_CNT,   "rs_cnt_pre",   32'd3);
    check_at_negedge();
    rst = 1'b0;
    #1;
    push(c_STALL, "rs_stall_same", 32'd0);
    pop_check();
    tick();
    rst = 1'b1;
    drive_id(1'b0, 1'b0, '0, 1'b0);
    push(c_STALL, "rs_stall_post", 32'd0);
    push(c_CNT,   "rs_cnt_post",   32'd0);
    push(c_OP0,   "rs_op0",        32'h0000_0030);
    push(c_OP1,   "rs_op1",        32'h0000_0031);
    check_at_negedge();
    tick();
    push(c_OP0,   "rs_op0_late",   32'h0000_0030);
    push(c_STALL, "rs_stall_late", 32'd0);
    check_at_negedge();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
